// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared state encoding and checksum width for the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int CSUM_WIDTH = 16;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] c_st_idle   = 3'd0;
  localparam logic [STATE_W-1:0] c_st_write  = 3'd1;
  localparam logic [STATE_W-1:0] c_st_verify = 3'd2;
  localparam logic [STATE_W-1:0] c_st_drain  = 3'd3;
  localparam logic [STATE_W-1:0] c_st_done   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mem_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : mem_checksum
//  Description : Clearable, enable-gated modular (wrap-around) adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_checksum
  import mem_pkg::*;
#(
  parameter int WIDTH = CSUM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] r_sum;

  // Clear wins over enable so a new job never inherits a stale word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum + din;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader
//  Description : Stream-to-RAM loader with optional checksum readback pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  verify_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] c_full_len = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] c_one      = CW'(1);

  logic [STATE_W-1:0]    r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_len;
  logic                  r_verify;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         r_ww;
  logic                  r_err;
  logic                  r_rd_vld;

  logic [CW-1:0]         w_len_clamped;
  logic                  w_start_acc;
  logic                  w_xfer;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wr_sum;
  logic [DATA_WIDTH-1:0] w_rd_sum;
  logic [DATA_WIDTH-1:0] w_rd_final;

  assign w_len_clamped = (length > c_full_len) ? c_full_len : length;
  assign w_start_acc   = (r_state == c_st_idle) && start;
  assign w_xfer        = (r_state == c_st_write) && in_valid;
  assign w_last        = (r_idx == (r_len - c_one));
  // Address arithmetic is ADDR_WIDTH wide, so the wrap at the top is free.
  assign w_addr        = r_base + r_idx[ADDR_WIDTH-1:0];
  // The last read word arrives during DRAIN and is folded in here directly.
  assign w_rd_final    = w_rd_sum + mem_out;

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (r_state)
      c_st_write: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        mem_addr = w_addr;
        mem_data = in_data;
      end
      c_st_verify: begin
        mem_addr = w_addr;
      end
      default: ;
    endcase
  end

  assign busy          = (r_state != c_st_idle);
  assign done          = (r_state == c_st_done);
  assign error         = r_err;
  assign words_written = r_ww;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_base   <= '0;
      r_len    <= '0;
      r_verify <= 1'b0;
      r_idx    <= '0;
      r_ww     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= w_len_clamped;
            r_verify <= verify_en;
            r_idx    <= '0;
            r_ww     <= '0;
            r_err    <= 1'b0;
            r_state  <= (w_len_clamped == '0) ? c_st_done : c_st_write;
          end
        end
        c_st_write: begin
          if (w_xfer) begin
            r_ww <= r_ww + c_one;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= r_verify ? c_st_verify : c_st_done;
            end else begin
              r_idx <= r_idx + c_one;
            end
          end
        end
        c_st_verify: begin
          if (w_last) begin
            r_idx   <= '0;
            r_state <= c_st_drain;
          end else begin
            r_idx <= r_idx + c_one;
          end
        end
        c_st_drain: begin
          r_err   <= (w_rd_final != w_wr_sum);
          r_state <= c_st_done;
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Marks cycles whose mem_out belongs to an address issued in VERIFY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == c_st_verify);
    end
  end

  mem_checksum #(
    .WIDTH (DATA_WIDTH)
  ) u_wr_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_acc),
    .en    (w_xfer),
    .din   (in_data),
    .sum   (w_wr_sum)
  );

  mem_checksum #(
    .WIDTH (DATA_WIDTH)
  ) u_rd_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_acc),
    .en    (r_rd_vld),
    .din   (mem_out),
    .sum   (w_rd_sum)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_loader
//  Description : Self-checking bench for mem_loader with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic        verify_en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  words_written;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .verify_en     (verify_en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_out       (mem_out),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  // Write-first single-port memory with a registered read, plus a fault hook.
  logic [15:0] mem [64];
  logic [15:0] mem_q;
  logic        flip;
  logic [15:0] flip_mask;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q <= mem_we ? mem_data : mem[mem_addr];
  end
  assign mem_out = flip ? (mem_q ^ flip_mask) : mem_q;

  int n_checks = 0;
  int n_errors = 0;
  int jc;
  int done_cyc;
  int err_at_done;

  logic [15:0] exp_mem [64];
  bit          exp_wr  [64];

  bit chk_on;
  int e_rdy, e_we, e_achk, e_addr, e_dchk, e_data, e_busy, e_done, e_err, e_ww;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (job cycle %0d)", nm, act, exp, jc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", int'(in_ready), e_rdy);
      chk("mem_we", int'(mem_we), e_we);
      if (e_achk != 0) chk("mem_addr", int'(mem_addr), e_addr);
      if (e_dchk != 0) chk("mem_data", int'(mem_data), e_data);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("error", int'(error), e_err);
      chk("words_written", int'(words_written), e_ww);
      if (done) begin
        done_cyc    = jc;
        err_at_done = int'(error);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_rdy = 0; e_we = 0; e_achk = 0; e_dchk = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic set_reset_exp();
    e_rdy = 0; e_we = 0; e_achk = 1; e_addr = 0; e_dchk = 1; e_data = 0;
    e_busy = 0; e_done = 0; e_err = 0; e_ww = 0;
  endtask

  // One complete job: drives the stream and predicts every output cycle by cycle.
  task automatic run_job(input int base, input int len_in, input bit ver, input int stall_pct,
                         input logic [31:0] stall_cyc, input bit do_flip, input bit mid_start,
                         input int abort_after, input bit seq_data);
    int L, n, a;
    bit v;
    logic [15:0] wsum, rsum;
    logic [15:0] words [64];
    L = (len_in > 64) ? 64 : len_in;
    for (int i = 0; i < 64; i++)
      words[i] = seq_data ? 16'((i + 1) * 16'h1111) : 16'($urandom);
    done_cyc = -1;
    err_at_done = -1;

    jc = 0;
    start = 1'b1; base_addr = 6'(base); length = 7'(len_in); verify_en = ver; in_valid = 1'b0;
    set_idle_exp();
    tick();
    start = 1'b0; jc = 1; e_err = 0; e_ww = 0;

    if (L == 0) begin
      e_busy = 1; e_done = 1;
      tick(); jc++;
      set_idle_exp();
      tick();
      return;
    end

    n = 0; wsum = '0;
    while (n < L) begin
      v = 1'b1;
      if (jc < 32 && stall_cyc[jc]) v = 1'b0;
      if ($urandom_range(99) < stall_pct) v = 1'b0;
      if (abort_after >= 0 && n == abort_after) v = 1'b0;
      start = mid_start && (jc == 2);
      if (start) base_addr = 6'($urandom);
      in_valid = v;
      in_data  = v ? words[n] : 16'($urandom);
      e_rdy = 1; e_we = v; e_achk = v; e_addr = (base + n) % 64; e_dchk = v; e_data = words[n];
      e_busy = 1; e_done = 0; e_ww = n;
      if (abort_after >= 0 && n == abort_after) rst_n = 1'b0;
      tick(); jc++;
      if (!rst_n) begin
        rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
        set_reset_exp();
        tick(); jc++;
        set_idle_exp();
        return;
      end
      if (v) begin
        a = (base + n) % 64;
        exp_mem[a] = words[n];
        exp_wr[a]  = 1'b1;
        wsum = wsum + words[n];
        n++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    e_ww = L;

    if (ver) begin
      rsum = '0;
      for (int k = 0; k < L; k++) begin
        rsum = rsum + exp_mem[(base + k) % 64];
        e_rdy = 0; e_we = 0; e_achk = 1; e_addr = (base + k) % 64; e_dchk = 0; e_busy = 1; e_done = 0;
        tick(); jc++;
      end
      flip_mask = 16'(1 << $urandom_range(15));
      flip = do_flip;
      if (do_flip) rsum = rsum ^ exp_mem[(base + L - 1) % 64] ^ (exp_mem[(base + L - 1) % 64] ^ flip_mask);
      e_achk = 0;
      tick(); jc++;
      flip = 1'b0;
      e_err = (rsum != wsum) ? 1 : 0;
    end

    e_rdy = 0; e_we = 0; e_achk = 0; e_dchk = 0; e_busy = 1; e_done = 1;
    tick(); jc++;
    set_idle_exp();
    tick();

    for (int i = 0; i < 64; i++)
      if (exp_wr[i]) chk("mem_content", int'(mem[i]), int'(exp_mem[i]));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; verify_en = 1'b0;
    in_data = '0; in_valid = 1'b0; flip = 1'b0; flip_mask = '0; chk_on = 1'b0; jc = 0;
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = '0;
      exp_wr[i]  = 1'b0;
    end
    tick(); tick();
    set_reset_exp();
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    set_idle_exp();
    tick();

    // Base 0, four sequential words, no verify.
    run_job(0, 4, 1'b0, 0, 32'h0, 1'b0, 1'b0, -1, 1'b1);
    chk("job1_done_cycle", done_cyc, 5);
    chk("job1_words_written", int'(words_written), 4);
    chk("job1_mem0", int'(mem[0]), 16'h1111);
    chk("job1_mem3", int'(mem[3]), 16'h4444);

    // Wrapping region with verify.
    run_job(62, 4, 1'b1, 0, 32'h0, 1'b0, 1'b0, -1, 1'b0);
    chk("job2_done_cycle", done_cyc, 10);
    chk("job2_error", err_at_done, 0);

    // Same job with stalls in cycles 2..4.
    run_job(62, 4, 1'b1, 0, 32'h1C, 1'b0, 1'b0, -1, 1'b0);
    chk("stall_done_cycle", done_cyc, 13);

    run_job(9, 0, 1'b1, 0, 32'h0, 1'b0, 1'b0, -1, 1'b0);
    chk("len0_done_cycle", done_cyc, 1);

    run_job(17, 100, 1'b0, 0, 32'h0, 1'b0, 1'b0, -1, 1'b0);
    chk("len100_done_cycle", done_cyc, 65);
    chk("len100_words_written", int'(words_written), 64);

    // Corrupted readback, then a clean job that must clear the flag.
    run_job(5, 7, 1'b1, 0, 32'h0, 1'b1, 1'b0, -1, 1'b0);
    chk("flip_error", err_at_done, 1);
    run_job(40, 3, 1'b1, 0, 32'h0, 1'b0, 1'b0, -1, 1'b0);
    chk("flip_cleared", err_at_done, 0);

    // Reset after two words, then a start pulse while busy.
    run_job(20, 8, 1'b1, 0, 32'h0, 1'b0, 1'b0, 2, 1'b0);
    run_job(30, 6, 1'b1, 0, 32'h0, 1'b0, 1'b1, -1, 1'b0);
    chk("midstart_done_cycle", done_cyc, 14);

    for (int j = 0; j < 12; j++) begin
      int rl;
      rl = ($urandom_range(3) == 0) ? $urandom_range(127) : $urandom_range(12);
      run_job($urandom_range(63), rl, 1'($urandom), 30, 32'h0, 1'($urandom),
              1'($urandom), -1, 1'b0);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
# mem_loader

Stream-to-RAM loader placed directly upstream of the single-port synchronous `memory` block (write-first, 1-cycle registered read). On a `start` pulse it accepts a valid/ready stream of words and writes them to consecutive addresses from `base_addr`, wrapping at the top of the address space. It then optionally reads the region back and compares a running checksum against the written data. Used for program/data preload before the core is released and for memory self-checks.

## Interface
- `ADDR_WIDTH`, 6, memory address width; must match the downstream `memory`.
- `DATA_WIDTH`, 16, word width; must match the downstream `memory`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin job; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address; latched at start.
- `length`  in  ADDR_WIDTH+1  words to load; latched at start; values above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH.
- `verify_en`  in  1  run readback pass; latched at start.
- `in_data`  in  DATA_WIDTH  stream word.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  to `memory.we`.
- `mem_addr`  out  ADDR_WIDTH  to `memory.addr`.
- `mem_data`  out  DATA_WIDTH  to `memory.data`.
- `mem_out`  in  DATA_WIDTH  from `memory.out`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `error`  out  1  checksum mismatch on last verified job; held until next accepted start.
- `words_written`  out  ADDR_WIDTH+1  count of words accepted in current or last job.

## Operation
- States: IDLE, WRITE, VERIFY, DRAIN, DONE. Reset state is IDLE.
- IDLE → WRITE on `start`. Latch parameters, clear index, checksums, `words_written` and `error`. If clamped length is 0, go IDLE → DONE.
- WRITE: `in_ready`=1. A transfer occurs when `in_valid && in_ready`. On each transfer:
  - `mem_we`=1, `mem_addr`=base+idx (mod 2^ADDR_WIDTH), `mem_data`=`in_data`.
  - Add the word to the write checksum (sum mod 2^DATA_WIDTH).
  - Increment idx and `words_written`.
- Leaving WRITE, after the transfer with idx=length-1: go to VERIFY if `verify_en`, otherwise DONE.
- VERIFY: `mem_we`=0. Drive `mem_addr`=base+k for k=0..length-1, one address per cycle, with no stalls. `mem_out` is taken one cycle after each address and added to the read checksum. After the last address, go to DRAIN.
- DRAIN: absorb the final `mem_out`. `error` <= (read checksum != write checksum). Go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `mem_we`, `in_ready` and `mem_addr` are combinational from state and index. `mem_we`=0 outside WRITE.
- `start` while busy is ignored.
- `in_valid` low in WRITE stalls the job indefinitely. No timeout.
- Address wrap: base 62, length 4 gives addresses 62, 63, 0, 1.
- Length 2^ADDR_WIDTH overwrites the whole memory exactly once.
- Reset mid-job: synchronous return to IDLE with all outputs at reset values. Memory contents already written are kept.
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_data` 0, `busy` 0, `done` 0, `error` 0, `words_written` 0.

## Timing
- `start` sampled at edge 0 → WRITE from cycle 1, with `in_ready` high in cycle 1.
- One word per cycle when `in_valid` is held high.
- No verify, L words, no stalls: `done` is high in cycle L+1, and `busy` falls in cycle L+2.
- Verify: `done` is high in cycle 2L+2, and `error` is valid from the same cycle.
- A write lands in memory at the edge that ends the transfer cycle.
- VERIFY starts the cycle after the last write, so the write-first memory returns the new data.

## Structure
- Shared package `mem_pkg`: state encoding constants and the checksum width (= DATA_WIDTH).
- Sub-module `mem_checksum`: clearable, enable-gated modular adder. Two instances are used: write checksum and read checksum.
- Counters and FSM live in `mem_loader`.

## Test plan
- Base 0, length 4, verify off, stream 0x1111, 0x2222, 0x3333, 0x4444 back-to-back → mem[0..3] hold the data, `done` in cycle 5, `words_written`=4.
- Base 62, length 4, verify on → writes at 62, 63, 0, 1; `done` in cycle 10; `error`=0.
- Same job with `in_valid` low on cycles 2–4 → the three stall cycles extend WRITE; data and addresses are unchanged; `done` is 3 cycles later.
- Length 0, and length 100 (clamps to 64) → `done` in cycle 1 with no `mem_we`; and 64 writes covering all addresses, respectively.
- Force `mem_out` bit flip during VERIFY (bench model) → `error`=1 with `done`; the next `start` clears `error`.
- Assert `rst_n`=0 mid-WRITE after 2 words → next cycle IDLE with all outputs at reset values; `start` pulsed while busy in another run is ignored.
